// File: rtl/mem_responder_pkg.sv
// Shared types and constants for the mem_responder slave.
package mem_responder_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP,
        TURN
    } state_e;

    typedef enum logic {
        OP_READ,
        OP_WRITE
    } op_e;

    localparam int LATENCY_MAX = 15;
    localparam int CNT_W       = $clog2(LATENCY_MAX + 1);

endpackage

// File: rtl/mem_responder_array.sv
// Single-port word RAM: two byte-lane write enables, registered read.
module mem_array #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  clear_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic                  rd_en_i,
    input  logic [1:0]            we_i,
    input  logic [15:0]           wdata_i,
    output logic [15:0]           rdata_o
);

    logic [15:0] mem_q [0:(2**ADDR_WIDTH)-1];
    logic [15:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i[0]) begin
            mem_q[addr_i][7:0] <= wdata_i[7:0];
        end
        if (we_i[1]) begin
            mem_q[addr_i][15:8] <= wdata_i[15:8];
        end
    end

    // Output register holds the last read word until the next read or clear.
    always_ff @(posedge clk) begin
        if (clear_i) begin
            rdata_q <= '0;
        end else if (rd_en_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Fixed-latency memory slave for the mem_read/mem_write/mem_resp handshake.
// Define MEM_RESPONDER_ERR_EN to enable the mem_err pulse.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int LATENCY    = 2,
    parameter int DATA_WIDTH = 16
) (
    input  logic        clk,
    input  logic        clear,
    input  logic [15:0] mem_address,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [1:0]  mem_byte_enable,
    input  logic [15:0] mem_wdata,
    output logic [15:0] mem_rdata,
    output logic        mem_resp,
    output logic        mem_err
);

    if (DATA_WIDTH != 16) begin : g_bad_dw
        $error("mem_responder: DATA_WIDTH must be 16");
    end
    if (LATENCY < 1 || LATENCY > LATENCY_MAX) begin : g_bad_lat
        $error("mem_responder: LATENCY out of range 1..15");
    end
    if (ADDR_WIDTH < 1 || ADDR_WIDTH > 15) begin : g_bad_aw
        $error("mem_responder: ADDR_WIDTH out of range 1..15");
    end

    localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(LATENCY - 1);

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [1:0]              be_q, be_d;
    op_e                     op_q, op_d;
    logic                    resp_q, resp_d;
    logic                    req;
    logic                    ram_rd;
    logic [1:0]              ram_we;

    assign req = mem_read | mem_write;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        op_d    = op_q;
        resp_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req) begin
                    addr_d  = mem_address[ADDR_WIDTH-1:0];
                    wdata_d = mem_wdata;
                    be_d    = mem_byte_enable;
                    op_d    = mem_write ? OP_WRITE : OP_READ;
                    cnt_d   = CNT_W'(1);
                    state_d = (LATENCY > 1) ? WAIT : RESP;
                end
            end
            WAIT: begin
                // A requester that drops both strobes abandons the access.
                if (!req) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == LAT_M1) begin
                        state_d = RESP;
                    end
                end
            end
            RESP: begin
                cnt_d   = '0;
                resp_d  = 1'b1;
                state_d = TURN;
            end
            TURN: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            resp_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            resp_q  <= resp_d;
        end
    end

    always_ff @(posedge clk) begin
        addr_q  <= addr_d;
        wdata_q <= wdata_d;
        be_q    <= be_d;
        op_q    <= op_d;
    end

    // The RAM access lands on the edge that raises mem_resp.
    assign ram_rd = (state_q == RESP) && (op_q == OP_READ) && !clear;
    assign ram_we = ((state_q == RESP) && (op_q == OP_WRITE) && !clear)
                  ? be_q : 2'b00;

    mem_array #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_array (
        .clk     (clk),
        .clear_i (clear),
        .addr_i  (addr_q),
        .rd_en_i (ram_rd),
        .we_i    (ram_we),
        .wdata_i (wdata_q),
        .rdata_o (mem_rdata)
    );

    assign mem_resp = resp_q;

`ifdef MEM_RESPONDER_ERR_EN
    logic err_q, err_d;
    logic err_out_q;

    always_comb begin
        err_d = err_q;
        if (state_q == IDLE && req) begin
            err_d = (mem_read & mem_write)
                  | (|mem_address[15:ADDR_WIDTH]);
        end
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            err_q     <= 1'b0;
            err_out_q <= 1'b0;
        end else begin
            err_q     <= err_d;
            err_out_q <= (state_q == RESP) && err_q;
        end
    end

    assign mem_err = err_out_q;
`else
    logic unused_addr_hi;
    assign unused_addr_hi = ^mem_address[15:ADDR_WIDTH];
    assign mem_err        = 1'b0;
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: three instances (LATENCY 2, 1, 5) against a transaction model.
module tb_mem_responder;

    localparam int N = 3;
`ifdef MEM_RESPONDER_ERR_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        clr  [N];
    logic        rd   [N];
    logic        wr   [N];
    logic [15:0] ad   [N];
    logic [15:0] wd   [N];
    logic [1:0]  be   [N];
    logic [15:0] rdat [N];
    logic        rsp  [N];
    logic        er   [N];

    always #5 clk = ~clk;

    mem_responder #(.ADDR_WIDTH(8), .LATENCY(2), .DATA_WIDTH(16)) u0 (
        .clk(clk), .clear(clr[0]), .mem_address(ad[0]), .mem_read(rd[0]),
        .mem_write(wr[0]), .mem_byte_enable(be[0]), .mem_wdata(wd[0]),
        .mem_rdata(rdat[0]), .mem_resp(rsp[0]), .mem_err(er[0]));

    mem_responder #(.ADDR_WIDTH(8), .LATENCY(1), .DATA_WIDTH(16)) u1 (
        .clk(clk), .clear(clr[1]), .mem_address(ad[1]), .mem_read(rd[1]),
        .mem_write(wr[1]), .mem_byte_enable(be[1]), .mem_wdata(wd[1]),
        .mem_rdata(rdat[1]), .mem_resp(rsp[1]), .mem_err(er[1]));

    mem_responder #(.ADDR_WIDTH(8), .LATENCY(5), .DATA_WIDTH(16)) u2 (
        .clk(clk), .clear(clr[2]), .mem_address(ad[2]), .mem_read(rd[2]),
        .mem_write(wr[2]), .mem_byte_enable(be[2]), .mem_wdata(wd[2]),
        .mem_rdata(rdat[2]), .mem_resp(rsp[2]), .mem_err(er[2]));

    int          lats  [N];
    int          cyc;
    int          ready [N];
    bit          pv    [N];
    int          pe    [N];
    bit          pw    [N];
    logic [1:0]  pb    [N];
    logic [7:0]  pa    [N];
    logic [15:0] pd    [N];
    bit          perr  [N];
    logic [15:0] mm    [N][256];
    logic [15:0] rdm   [N];
    int          ncmp;
    int          nfail;
    bit          run_cmp;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int d,
                       input logic [15:0] act, input logic [15:0] exp);
        ncmp++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s dut%0d got=%h want=%h", nm, d, act, exp);
        end
    endtask

    function automatic bit err_of(bit r, bit w, logic [15:0] a);
`ifdef MEM_RESPONDER_ERR_EN
        return (r && w) || (a[15:8] != 8'h00);
`else
        return 1'b0;
`endif
    endfunction

    // Model: a response is due LATENCY edges after the accept edge.
    always @(negedge clk) begin
        logic er_e;
        logic ee;
        if (run_cmp) begin
            for (int d = 0; d < N; d++) begin
                er_e = 1'b0;
                ee   = 1'b0;
                if (pv[d] && cyc == pe[d]) begin
                    er_e = 1'b1;
                    ee   = perr[d];
                    if (pw[d]) begin
                        if (pb[d][0]) mm[d][pa[d]][7:0]  = pd[d][7:0];
                        if (pb[d][1]) mm[d][pa[d]][15:8] = pd[d][15:8];
                    end else begin
                        rdm[d] = mm[d][pa[d]];
                    end
                    pv[d] = 1'b0;
                end
                chk("resp", d, 16'(rsp[d]), 16'(er_e));
                chk("rdata", d, rdat[d], rdm[d]);
                chk("err", d, 16'(er[d]), 16'(ee));
            end
        end
    end

    task automatic txn(input int d, input bit r, input bit w,
                       input logic [15:0] a, input logic [1:0] b,
                       input logic [15:0] dat,
                       output int re, output logic e);
        int acc;
        @(negedge clk);
        #1;
        rd[d] = r;
        wr[d] = w;
        ad[d] = a;
        be[d] = b;
        wd[d] = dat;
        acc     = (cyc + 1 > ready[d]) ? cyc + 1 : ready[d];
        pv[d]   = 1'b1;
        pe[d]   = acc + lats[d];
        pw[d]   = w;
        pb[d]   = b;
        pa[d]   = a[7:0];
        pd[d]   = dat;
        perr[d] = err_of(r, w, a);
        ready[d] = acc + lats[d] + 2;
        re = -1;
        e  = 1'b0;
        for (int t = 0; t < 40 && re < 0; t++) begin
            @(posedge clk);
            #1;
            if (rsp[d]) begin
                re = cyc;
                e  = er[d];
            end
        end
        if (re < 0) begin
            ncmp++;
            nfail++;
            $display("FAIL resp_timeout dut%0d got=none want=resp", d);
            pv[d] = 1'b0;
        end
        rd[d] = 1'b0;
        wr[d] = 1'b0;
    endtask

    // Start a write and kill it k edges after accept, by abort or clear.
    task automatic abrt(input int d, input logic [15:0] a,
                        input logic [15:0] dat, input int k,
                        input bit use_clr);
        int acc;
        @(negedge clk);
        #1;
        wr[d] = 1'b1;
        ad[d] = a;
        be[d] = 2'b11;
        wd[d] = dat;
        acc = (cyc + 1 > ready[d]) ? cyc + 1 : ready[d];
        while (cyc != acc + k - 1) begin
            @(negedge clk);
            #1;
        end
        wr[d] = 1'b0;
        if (use_clr) begin
            clr[d] = 1'b1;
            rdm[d] = '0;
            @(posedge clk);
            #1;
            clr[d]   = 1'b0;
            ready[d] = cyc + 1;
        end else begin
            ready[d] = acc + k + 1;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   c0;
        int   re;
        int   re2;
        logic e;
        lats = '{2, 1, 5};
        for (int d = 0; d < N; d++) begin
            clr[d] = 1'b1;
            rd[d]  = 1'b0;
            wr[d]  = 1'b0;
            ad[d]  = '0;
            wd[d]  = '0;
            be[d]  = '0;
            rdm[d] = '0;
            pv[d]  = 1'b0;
            ready[d] = 3;
            for (int i = 0; i < 256; i++) mm[d][i] = '0;
        end
        @(posedge clk);
        #1;
        run_cmp = 1'b1;
        @(posedge clk);
        #1;
        for (int d = 0; d < N; d++) clr[d] = 1'b0;
        chk("rst_rdata", 0, rdat[0], 16'h0000);
        chk("rst_resp", 0, 16'(rsp[0]), 16'h0000);
        chk("rst_err", 0, 16'(er[0]), 16'h0000);

        // Write then read, LATENCY=2
        c0 = cyc;
        txn(0, 0, 1, 16'h0010, 2'b11, 16'hBEEF, re, e);
        chk("wr_lat", 0, 16'(re - c0 - 1), 16'd2);
        idle(2);
        c0 = cyc;
        txn(0, 1, 0, 16'h0010, 2'b00, 16'h0000, re, e);
        chk("rd_lat", 0, 16'(re - c0 - 1), 16'd2);
        chk("rd_beef", 0, rdat[0], 16'hBEEF);

        // Byte lanes
        txn(0, 0, 1, 16'h0020, 2'b11, 16'h1234, re, e);
        txn(0, 0, 1, 16'h0020, 2'b10, 16'hAB00, re, e);
        txn(0, 1, 0, 16'h0020, 2'b00, 16'h0000, re, e);
        chk("be10", 0, rdat[0], 16'hAB34);
        txn(0, 0, 1, 16'h0020, 2'b01, 16'h00CD, re, e);
        txn(0, 1, 0, 16'h0020, 2'b00, 16'h0000, re, e);
        chk("be01", 0, rdat[0], 16'hABCD);
        txn(0, 0, 1, 16'h0020, 2'b00, 16'hFFFF, re, e);
        chk("be00_resp", 0, 16'(re >= 0), 16'h0001);
        txn(0, 1, 0, 16'h0020, 2'b00, 16'h0000, re, e);
        chk("be00_data", 0, rdat[0], 16'hABCD);

        // Abort mid-WAIT leaves the array alone
        abrt(0, 16'h0020, 16'h5555, 1, 1'b0);
        idle(3);
        txn(0, 1, 0, 16'h0020, 2'b00, 16'h0000, re, e);
        chk("abort_data", 0, rdat[0], 16'hABCD);

        // Aliasing and error flag
        txn(0, 0, 1, 16'h0155, 2'b11, 16'h7777, re, e);
        chk("alias_err", 0, 16'(e), 16'(EXP_ERR));
        txn(0, 1, 0, 16'h0055, 2'b00, 16'h0000, re, e);
        chk("alias_data", 0, rdat[0], 16'h7777);
        chk("alias_rd_err", 0, 16'(e), 16'h0000);
        txn(0, 1, 1, 16'h0055, 2'b11, 16'h8888, re, e);
        chk("rw_err", 0, 16'(e), 16'(EXP_ERR));
        chk("rw_rdata_hold", 0, rdat[0], 16'h7777);
        txn(0, 1, 0, 16'h0055, 2'b00, 16'h0000, re, e);
        chk("rw_wrote", 0, rdat[0], 16'h8888);

        // LATENCY=1 and back-to-back spacing
        idle(2);
        c0 = cyc;
        txn(1, 0, 1, 16'h0003, 2'b11, 16'h4242, re, e);
        chk("l1_lat", 1, 16'(re - c0 - 1), 16'd1);
        txn(1, 1, 0, 16'h0003, 2'b00, 16'h0000, re2, e);
        chk("l1_b2b", 1, 16'(re2 - re), 16'd3);
        chk("l1_data", 1, rdat[1], 16'h4242);

        // LATENCY=5, spacing, clear mid-WAIT, abort late in WAIT
        idle(2);
        c0 = cyc;
        txn(2, 0, 1, 16'h0030, 2'b11, 16'h1111, re, e);
        chk("l5_lat", 2, 16'(re - c0 - 1), 16'd5);
        txn(2, 1, 0, 16'h0030, 2'b00, 16'h0000, re2, e);
        chk("l5_b2b", 2, 16'(re2 - re), 16'd7);
        chk("l5_data", 2, rdat[2], 16'h1111);
        idle(2);
        abrt(2, 16'h0030, 16'h2222, 2, 1'b1);
        chk("clr_rdata", 2, rdat[2], 16'h0000);
        chk("clr_resp", 2, 16'(rsp[2]), 16'h0000);
        chk("clr_err", 2, 16'(er[2]), 16'h0000);
        txn(2, 1, 0, 16'h0030, 2'b00, 16'h0000, re, e);
        chk("clr_nocommit", 2, rdat[2], 16'h1111);
        idle(3);
        abrt(2, 16'h0030, 16'h3333, 3, 1'b0);
        idle(10);
        txn(2, 1, 0, 16'h0030, 2'b00, 16'h0000, re, e);
        chk("abort5_data", 2, rdat[2], 16'h1111);

        idle(4);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
